// File: rtl/datapath_seq.sv
// Single-bus datapath (register file, Y/Z/HI/LO, ALU, I/O ports) with a built-in micro-sequencer.
// Optional signed multiplier and T_HI state are enabled by defining DATAPATH_SEQ_MUL_EN.
module datapath_seq #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [RW-1:0]     ra,
    input  logic [RW-1:0]     rb,
    input  logic [RW-1:0]     rc,
    input  logic [DATA_W-1:0] in_port,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] bus_dbg,
    output logic [2:0]        state_dbg
);
    // Handshake: start is accepted only on a cycle with busy=0; op/ra/rb/rc are captured
    // at that edge. busy stays high through the last transfer state, and done pulses for
    // exactly one cycle in IDLE, where a new start may already be accepted.

    localparam int SW = $clog2(DATA_W);
`ifdef DATAPATH_SEQ_MUL_EN
    localparam int ZW = 2 * DATA_W;
`else
    localparam int ZW = DATA_W;
`endif

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_NEG  = 4'd7;
    localparam logic [3:0] OP_IN   = 4'd8;
    localparam logic [3:0] OP_OUT  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MFHI = 4'd11;
    localparam logic [3:0] OP_MFLO = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TY   = 3'd1,
        S_TZ   = 3'd2,
        S_TWB  = 3'd3,
        S_THI  = 3'd4,
        S_TMV  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q;
    logic [RW-1:0]     ra_q, rb_q, rc_q;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] y_q, hi_q, lo_q, out_q;
    logic [ZW-1:0]     z_q, alu_res;
    logic [DATA_W-1:0] bus;
    logic              accept, legal, done_d, done_q, err_q;

    function automatic logic is_legal(input logic [3:0] o);
`ifdef DATAPATH_SEQ_MUL_EN
        return o <= OP_MFLO;
`else
        return (o <= OP_MFLO) && (o != OP_MUL);
`endif
    endfunction

    function automatic logic is_move(input logic [3:0] o);
        return (o == OP_IN) || (o == OP_OUT) || (o == OP_MFHI) || (o == OP_MFLO);
    endfunction

    always_comb begin
        state_d = state_q;
        bus     = '0;
        accept  = 1'b0;
        legal   = is_legal(op);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (legal) state_d = is_move(op) ? S_TMV : S_TY;
                end
            end
            S_TY: begin
                bus     = regs[rb_q];
                state_d = S_TZ;
            end
            S_TZ: begin
                bus     = regs[rc_q];
                state_d = S_TWB;
            end
            S_TWB: begin
                bus     = z_q[DATA_W-1:0];
                state_d = S_IDLE;
`ifdef DATAPATH_SEQ_MUL_EN
                if (op_q == OP_MUL) state_d = S_THI;
`endif
            end
`ifdef DATAPATH_SEQ_MUL_EN
            S_THI: begin
                bus     = z_q[ZW-1:DATA_W];
                state_d = S_IDLE;
            end
`endif
            S_TMV: begin
                case (op_q)
                    OP_IN:   bus = in_port;
                    OP_OUT:  bus = regs[ra_q];
                    OP_MFHI: bus = hi_q;
                    OP_MFLO: bus = lo_q;
                    default: bus = '0;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Completion of a real sequence, or immediate rejection of an illegal op.
        done_d = ((state_q != S_IDLE) && (state_d == S_IDLE)) || (accept && !legal);
    end

`ifdef DATAPATH_SEQ_MUL_EN
    logic signed [ZW-1:0] y_ext, bus_ext;
    assign y_ext   = {{DATA_W{y_q[DATA_W-1]}}, y_q};
    assign bus_ext = {{DATA_W{bus[DATA_W-1]}}, bus};
`endif

    // ALU sees Y and the T_Z bus operand; NOT/NEG use only Y.
    always_comb begin
        alu_res = '0;
        case (op_q)
            OP_ADD:  alu_res = ZW'(y_q + bus);
            OP_SUB:  alu_res = ZW'(y_q - bus);
            OP_AND:  alu_res = ZW'(y_q & bus);
            OP_OR:   alu_res = ZW'(y_q | bus);
            OP_SHL:  alu_res = ZW'(y_q << bus[SW-1:0]);
            OP_SHR:  alu_res = ZW'(y_q >> bus[SW-1:0]);
            OP_NOT:  alu_res = ZW'(~y_q);
            OP_NEG:  alu_res = ZW'(-y_q);
`ifdef DATAPATH_SEQ_MUL_EN
            OP_MUL:  alu_res = y_ext * bus_ext;
`endif
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                op_q  <= op;
                ra_q  <= ra;
                rb_q  <= rb;
                rc_q  <= rc;
                err_q <= !legal;
            end
            case (state_q)
                S_TY:  y_q <= bus;
                S_TZ:  z_q <= alu_res;
                S_TWB: begin
`ifdef DATAPATH_SEQ_MUL_EN
                    if (op_q == OP_MUL) lo_q <= bus;
                    else regs[ra_q] <= bus;
`else
                    regs[ra_q] <= bus;
`endif
                end
`ifdef DATAPATH_SEQ_MUL_EN
                S_THI: hi_q <= bus;
`endif
                S_TMV: begin
                    if (op_q == OP_OUT) out_q <= bus;
                    else regs[ra_q] <= bus;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign out_port  = out_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign bus_dbg   = bus;
    assign state_dbg = state_q;

endmodule
